inst_mem_sync: RTL

INST_MEM_SYNC -- requirements
Module: inst_mem_sync

---
 rtl/inst_mem_sync_pkg.sv | 20 ++
 rtl/inst_mem_bytes.sv | 41 ++++
 rtl/inst_mem_sync.sv | 107 ++++++++++
 3 files changed

// File: rtl/inst_mem_sync_pkg.sv
// Shared types and constants for the instruction memory slice.
package inst_mem_sync_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Bit position inside a word of the byte at offset 'lane' from the word address.
  function automatic int lane_lsb(input int lane, input bit big_endian);
    return big_endian ? 8 * (3 - lane) : 8 * lane;
  endfunction

endpackage

// File: rtl/inst_mem_bytes.sv
// Byte-wide storage with endian-ordered 32-bit word write and read.
// Contents are deliberately not reset so a loaded program survives rst_n.
module inst_mem_bytes
  import inst_mem_sync_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [WORD_W-1:0]            rd_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [7:0] mem [MEM_DEPTH];

  // Scatter the word into four consecutive bytes in the configured byte order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        mem[wr_addr + AW'(i)] <= wr_data[lane_lsb(i, BIG_ENDIAN) +: 8];
      end
    end
  end

  // Gather four bytes into a word; a disabled read returns zero.
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      for (int i = 0; i < 4; i++) begin
        rd_data[lane_lsb(i, BIG_ENDIAN) +: 8] = mem[rd_addr + AW'(i)];
      end
    end
  end

endmodule

// File: rtl/inst_mem_sync.sv
// Instruction memory with a valid/ready fetch port, one-cycle response
// latency, address checking and a program-load write port that wins over fetches.
module inst_mem_sync
  import inst_mem_sync_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [WORD_W-1:0] fetch_addr,
  output logic              fetch_rsp_valid,
  input  logic              fetch_rsp_ready,
  output logic [WORD_W-1:0] fetch_instr,
  output logic [1:0]        fetch_err,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_err
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [31:0] LAST_WORD = 32'(MEM_DEPTH - 4);

  state_t            state;
  state_t            state_next;
  logic              fetch_accept;
  logic              load_ok;
  logic [1:0]        chk_err;
  logic [WORD_W-1:0] rd_word;

  assign fetch_req_ready = rst_n && !load_en && (state == IDLE || fetch_rsp_ready);
  assign fetch_accept    = fetch_req_valid && fetch_req_ready;
  assign fetch_rsp_valid = (state == RESP);
  assign load_ok         = load_en && (load_addr[1:0] == 2'b00) && (load_addr <= LAST_WORD);

  // Classify the fetch address: alignment first, then full 32-bit range.
  always_comb begin
    chk_err = ERR_OK;
    if (fetch_addr[1:0] != 2'b00) begin
      chk_err = ERR_MISALIGN;
    end else if (fetch_addr > LAST_WORD) begin
      chk_err = ERR_RANGE;
    end
  end

  inst_mem_bytes #(
    .MEM_DEPTH (MEM_DEPTH),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_bytes (
    .clk    (clk),
    .wr_en  (load_ok),
    .wr_addr(load_addr[AW-1:0]),
    .wr_data(load_data),
    .rd_en  (chk_err == ERR_OK),
    .rd_addr(fetch_addr[AW-1:0]),
    .rd_data(rd_word)
  );

  // Response state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stay in RESP while a response is held or replaced; drop to IDLE once taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (fetch_accept) state_next = RESP;
      RESP: begin
        if (fetch_accept) begin
          state_next = RESP;
        end else if (fetch_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the response payload only on acceptance so it holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_instr <= '0;
      fetch_err   <= ERR_OK;
    end else if (fetch_accept) begin
      fetch_instr <= rd_word;
      fetch_err   <= chk_err;
    end
  end

  // Sticky record of any dropped load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_err <= 1'b0;
    end else if (load_en && !load_ok) begin
      load_err <= 1'b1;
    end
  end

endmodule
